dmem_arbiter: RTL and testbench

- Two-requester arbiter that shares the single data memory (combinational read, synchronous write) between the core load/store path (port 0) and a DMA/debug master (port 1).
- Round-robin grant with valid/ready request handshake, a registered one-cycle response, and a locked mode for atomic read-modify-write sequences.
- A lock-timeout watchdog prevents a locked owner from stalling the other master indefinitely.
- Sits between the core datapath and the data memory instance in the top level.

---
 rtl/dmem_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin data memory arbiter with
// lock support for atomic sequences and a lock-timeout watchdog.
module dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              m0_req_valid,
  output logic              m0_req_ready,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [2:0]        m0_funct3,
  output logic              m0_rsp_valid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req_valid,
  output logic              m1_req_ready,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [2:0]        m1_funct3,
  output logic              m1_rsp_valid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_memwrite,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_load_type,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              lock_err
);

  localparam int TW = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {
    UNLOCKED,
    LOCKED0,
    LOCKED1
  } lock_e;

  lock_e             r_state;
  lock_e             w_state_nxt;
  logic              r_rr;
  logic [TW-1:0]     r_timer;
  logic [TW-1:0]     w_timer_nxt;
  logic              r_err;
  logic              w_err_nxt;
  logic              r_rsp0;
  logic              r_rsp1;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;
  logic              w_gnt0;
  logic              w_gnt1;

  // Grants are suppressed while in reset so no write can slip through.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (resetn) begin
      unique case (r_state)
        UNLOCKED: begin
          w_gnt0 = m0_req_valid && (!m1_req_valid || r_rr);
          w_gnt1 = m1_req_valid && (!m0_req_valid || !r_rr);
        end
        LOCKED0: w_gnt0 = m0_req_valid;
        LOCKED1: w_gnt1 = m1_req_valid;
        default: ;
      endcase
    end
  end

  assign m0_req_ready = w_gnt0;
  assign m1_req_ready = w_gnt1;

  always_comb begin
    mem_memwrite  = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    mem_load_type = 3'b000;
    unique case (1'b1)
      w_gnt0: begin
        mem_memwrite  = m0_we;
        mem_addr      = m0_addr;
        mem_wdata     = m0_wdata;
        mem_load_type = m0_funct3;
      end
      w_gnt1: begin
        mem_memwrite  = m1_we;
        mem_addr      = m1_addr;
        mem_wdata     = m1_wdata;
        mem_load_type = m1_funct3;
      end
      default: ;
    endcase
  end

  // An owner transfer always beats a timeout in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_err_nxt   = r_err;
    unique case (r_state)
      UNLOCKED: begin
        w_timer_nxt = '0;
        if (w_gnt0 && m0_lock)
          w_state_nxt = LOCKED0;
        else if (w_gnt1 && m1_lock)
          w_state_nxt = LOCKED1;
      end
      LOCKED0: begin
        if (w_gnt0) begin
          w_timer_nxt = '0;
          if (!m0_lock)
            w_state_nxt = UNLOCKED;
        end else if (r_timer == TW'(LOCK_MAX - 1)) begin
          w_state_nxt = UNLOCKED;
          w_timer_nxt = '0;
          w_err_nxt   = 1'b1;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      LOCKED1: begin
        if (w_gnt1) begin
          w_timer_nxt = '0;
          if (!m1_lock)
            w_state_nxt = UNLOCKED;
        end else if (r_timer == TW'(LOCK_MAX - 1)) begin
          w_state_nxt = UNLOCKED;
          w_timer_nxt = '0;
          w_err_nxt   = 1'b1;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      default: begin
        w_state_nxt = UNLOCKED;
        w_timer_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= UNLOCKED;
      r_timer <= '0;
      r_err   <= 1'b0;
      r_rr    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_err   <= w_err_nxt;
      if (w_gnt0)
        r_rr <= 1'b0;
      else if (w_gnt1)
        r_rr <= 1'b1;
    end
  end

  // Write responses carry zero data and act as acknowledges.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rsp0   <= 1'b0;
      r_rsp1   <= 1'b0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      r_rsp0 <= w_gnt0;
      r_rsp1 <= w_gnt1;
      if (w_gnt0)
        r_rdata0 <= m0_we ? '0 : mem_rdata;
      if (w_gnt1)
        r_rdata1 <= m1_we ? '0 : mem_rdata;
    end
  end

  assign m0_rsp_valid = r_rsp0;
  assign m1_rsp_valid = r_rsp1;
  assign m0_rdata     = r_rdata0;
  assign m1_rdata     = r_rdata1;
  assign lock_err     = r_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenario tests for dmem_arbiter
// with a four-cycle lock timeout.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        m0_req_valid, m0_req_ready, m0_we, m0_lock;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [2:0]  m0_funct3;
  logic        m0_rsp_valid;
  logic        m1_req_valid, m1_req_ready, m1_we, m1_lock;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [2:0]  m1_funct3;
  logic        m1_rsp_valid;
  logic        mem_memwrite;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_load_type;
  logic        lock_err;
  logic [31:0] rd_base = 32'hA5A5_0000;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  // Memory read data is a fixed function of the address.
  assign mem_rdata = rd_base ^ mem_addr;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .LOCK_MAX(4)) dut (
    .clk(clk), .resetn(resetn),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready),
    .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_funct3(m0_funct3),
    .m0_rsp_valid(m0_rsp_valid), .m0_rdata(m0_rdata),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready),
    .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_funct3(m1_funct3),
    .m1_rsp_valid(m1_rsp_valid), .m1_rdata(m1_rdata),
    .mem_memwrite(mem_memwrite), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_load_type(mem_load_type),
    .mem_rdata(mem_rdata), .lock_err(lock_err)
  );

  task automatic drv0(input logic v, input logic we, input logic lk,
                      input logic [31:0] a, input logic [31:0] d);
    m0_req_valid = v; m0_we = we; m0_lock = lk;
    m0_addr = a; m0_wdata = d; m0_funct3 = 3'b010;
  endtask

  task automatic drv1(input logic v, input logic we, input logic lk,
                      input logic [31:0] a, input logic [31:0] d);
    m1_req_valid = v; m1_we = we; m1_lock = lk;
    m1_addr = a; m1_wdata = d; m1_funct3 = 3'b010;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drv0(0, 0, 0, 0, 0);
    drv1(0, 0, 0, 0, 0);
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_vec++;
    if ({m0_rsp_valid, m1_rsp_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_rsp: got %b want 00", {m0_rsp_valid, m1_rsp_valid});
    end
    n_vec++;
    if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin
      n_err++;
      $display("FAIL reset_rdata: got %h/%h want 0/0", m0_rdata, m1_rdata);
    end
    n_vec++;
    if (lock_err !== 1'b0 || mem_memwrite !== 1'b0) begin
      n_err++;
      $display("FAIL reset_flags: err=%b we=%b want 0/0", lock_err, mem_memwrite);
    end
  endtask

  task automatic test_single_read();
    next_cyc();
    rd_base = 32'hDEADBEEF ^ 32'h10;
    drv0(1, 0, 0, 32'h10, 0);
    @(negedge clk);
    n_vec++;
    if (m0_req_ready !== 1'b1 || mem_memwrite !== 1'b0 || mem_addr !== 32'h10) begin
      n_err++;
      $display("FAIL rd_grant: rdy=%b we=%b addr=%h want 1/0/10",
               m0_req_ready, mem_memwrite, mem_addr);
    end
    next_cyc();
    drv0(0, 0, 0, 0, 0);
    @(negedge clk);
    n_vec++;
    if (m0_rsp_valid !== 1'b1 || m0_rdata !== 32'hDEADBEEF || m1_rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rd_rsp: v0=%b d=%h v1=%b want 1/deadbeef/0",
               m0_rsp_valid, m0_rdata, m1_rsp_valid);
    end
    next_cyc();
    @(negedge clk);
    n_vec++;
    if (m0_rsp_valid !== 1'b0 || m0_rdata !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL rd_hold: v0=%b d=%h want 0/deadbeef", m0_rsp_valid, m0_rdata);
    end
  endtask

  task automatic test_contention();
    logic exp0;
    do_reset();
    rd_base = 32'h5555_0000;
    drv0(1, 0, 0, 32'h100, 0);
    drv1(1, 0, 0, 32'h200, 0);
    for (int i = 0; i < 4; i++) begin
      exp0 = (i % 2 == 0);
      @(negedge clk);
      n_vec++;
      if (m0_req_ready !== exp0 || m1_req_ready !== !exp0) begin
        n_err++;
        $display("FAIL rr_grant%0d: rdy=%b%b want %b%b", i,
                 m0_req_ready, m1_req_ready, exp0, !exp0);
      end
      if (i > 0) begin
        n_vec++;
        if (m0_rsp_valid !== !exp0 || m1_rsp_valid !== exp0) begin
          n_err++;
          $display("FAIL rr_rsp%0d: rsp=%b%b want %b%b", i,
                   m0_rsp_valid, m1_rsp_valid, !exp0, exp0);
        end
      end
      next_cyc();
    end
    drv0(0, 0, 0, 0, 0);
    drv1(0, 0, 0, 0, 0);
    @(negedge clk);
    n_vec++;
    if (m0_rsp_valid !== 1'b0 || m1_rsp_valid !== 1'b1 ||
        m0_rdata !== 32'h5555_0100 || m1_rdata !== 32'h5555_0200) begin
      n_err++;
      $display("FAIL rr_last: rsp=%b%b d0=%h d1=%h want 01/55550100/55550200",
               m0_rsp_valid, m1_rsp_valid, m0_rdata, m1_rdata);
    end
  endtask

  task automatic test_write();
    next_cyc();
    drv1(1, 1, 0, 32'h20, 32'h12345678);
    @(negedge clk);
    n_vec++;
    if (m1_req_ready !== 1'b1 || mem_memwrite !== 1'b1 || mem_addr !== 32'h20 ||
        mem_wdata !== 32'h12345678 || mem_load_type !== 3'b010) begin
      n_err++;
      $display("FAIL wr_drive: rdy=%b we=%b a=%h d=%h t=%b want 1/1/20/12345678/010",
               m1_req_ready, mem_memwrite, mem_addr, mem_wdata, mem_load_type);
    end
    next_cyc();
    drv1(0, 0, 0, 0, 0);
    @(negedge clk);
    n_vec++;
    if (m1_rsp_valid !== 1'b1 || m1_rdata !== 32'h0 || mem_memwrite !== 1'b0) begin
      n_err++;
      $display("FAIL wr_ack: v1=%b d=%h we=%b want 1/0/0",
               m1_rsp_valid, m1_rdata, mem_memwrite);
    end
  endtask

  task automatic test_back_to_back();
    next_cyc();
    rd_base = 32'h0F0F_0000;
    for (int i = 0; i < 3; i++) begin
      drv0(1, 0, 0, 32'h40 + 32'(4 * i), 0);
      @(negedge clk);
      if (i > 0) begin
        n_vec++;
        if (m0_rsp_valid !== 1'b1 || m0_rdata !== (32'h0F0F_0040 + 32'(4 * (i - 1)))) begin
          n_err++;
          $display("FAIL b2b%0d: v=%b d=%h want 1/%h", i, m0_rsp_valid, m0_rdata,
                   32'h0F0F_0040 + 32'(4 * (i - 1)));
        end
      end
      next_cyc();
    end
    drv0(0, 0, 0, 0, 0);
    @(negedge clk);
    n_vec++;
    if (m0_rsp_valid !== 1'b1 || m0_rdata !== 32'h0F0F_0048) begin
      n_err++;
      $display("FAIL b2b_last: v=%b d=%h want 1/0f0f0048", m0_rsp_valid, m0_rdata);
    end
  endtask

  task automatic test_lock();
    do_reset();
    drv0(1, 0, 1, 32'h30, 0);
    @(negedge clk);
    n_vec++;
    if (m0_req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL lk_take: rdy0=%b want 1", m0_req_ready);
    end
    next_cyc();
    drv0(0, 0, 1, 0, 0);
    drv1(1, 0, 0, 32'h44, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if (m1_req_ready !== 1'b0 || mem_addr !== 32'h0) begin
        n_err++;
        $display("FAIL lk_block%0d: rdy1=%b addr=%h want 0/0", i, m1_req_ready, mem_addr);
      end
      next_cyc();
    end
    drv0(1, 1, 0, 32'h30, 32'hCAFE);
    @(negedge clk);
    n_vec++;
    if (m0_req_ready !== 1'b1 || m1_req_ready !== 1'b0 || mem_memwrite !== 1'b1) begin
      n_err++;
      $display("FAIL lk_release: rdy=%b%b we=%b want 10/1",
               m0_req_ready, m1_req_ready, mem_memwrite);
    end
    next_cyc();
    drv0(0, 0, 0, 0, 0);
    @(negedge clk);
    n_vec++;
    if (m1_req_ready !== 1'b1 || lock_err !== 1'b0 || m0_rsp_valid !== 1'b1) begin
      n_err++;
      $display("FAIL lk_after: rdy1=%b err=%b v0=%b want 1/0/1",
               m1_req_ready, lock_err, m0_rsp_valid);
    end
    next_cyc();
    drv1(0, 0, 0, 0, 0);
  endtask

  task automatic test_timeout();
    do_reset();
    drv0(1, 0, 1, 32'h60, 0);
    next_cyc();
    drv0(0, 0, 1, 0, 0);
    drv1(1, 0, 0, 32'h70, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_vec++;
      if (m1_req_ready !== 1'b0 || lock_err !== 1'b0) begin
        n_err++;
        $display("FAIL to_wait%0d: rdy1=%b err=%b want 0/0", i, m1_req_ready, lock_err);
      end
      next_cyc();
    end
    @(negedge clk);
    n_vec++;
    if (m1_req_ready !== 1'b1 || lock_err !== 1'b1) begin
      n_err++;
      $display("FAIL to_fire: rdy1=%b err=%b want 1/1", m1_req_ready, lock_err);
    end
    next_cyc();
    drv1(0, 0, 0, 0, 0);
    repeat (2) next_cyc();
    @(negedge clk);
    n_vec++;
    if (lock_err !== 1'b1) begin
      n_err++;
      $display("FAIL to_sticky: err=%b want 1", lock_err);
    end
  endtask

  task automatic test_reset_midflight();
    next_cyc();
    rd_base = 32'h1111_0000;
    drv0(1, 0, 0, 32'h50, 0);
    next_cyc();
    drv0(1, 1, 0, 32'h54, 32'hBAD0);
    resetn = 1'b0;
    #1;
    n_vec++;
    if (m0_rsp_valid !== 1'b0 || m0_rdata !== 32'h0 || lock_err !== 1'b0 ||
        mem_memwrite !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: v=%b d=%h err=%b we=%b want 0/0/0/0",
               m0_rsp_valid, m0_rdata, lock_err, mem_memwrite);
    end
    @(negedge clk);
    n_vec++;
    if (m0_req_ready !== 1'b0 || mem_memwrite !== 1'b0) begin
      n_err++;
      $display("FAIL mid_hold: rdy=%b we=%b want 0/0", m0_req_ready, mem_memwrite);
    end
    drv0(0, 0, 0, 0, 0);
    next_cyc();
    resetn = 1'b1;
  endtask

  initial begin
    drv0(0, 0, 0, 0, 0);
    drv1(0, 0, 0, 0, 0);
    test_reset();
    test_single_read();
    test_contention();
    test_write();
    test_back_to_back();
    test_lock();
    test_timeout();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1);
  end

endmodule
